// File: rtl/ip_cfg_regbank_if.sv
// Single-word req/ack access bus between the NoC decoder and the
// configuration register bank.
interface ip_cfg_regbank_if #(
    parameter int SIZE_REG = 32,
    parameter int ADDR_W   = 3
);
    logic                req_i;
    logic                wr_i;
    logic [ADDR_W-1:0]   addr_i;
    logic [SIZE_REG-1:0] wdata_i;
    logic                ack_o;
    logic [SIZE_REG-1:0] rdata_o;
    logic                err_o;

    modport master (
        output req_i, wr_i, addr_i, wdata_i,
        input  ack_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, wr_i, addr_i, wdata_i,
        output ack_o, rdata_o, err_o
    );
endinterface

// File: rtl/ip_cfg_regbank.sv
// Configuration/status register bank for an IP-core NoC interface:
// ID, CTRL, STATUS, SCRATCH and a done counter behind a req/ack handshake.
module ip_cfg_regbank #(
    parameter int SIZE_REG = 32,
    parameter int ADDR_W   = 3,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SIZE_REG-1:0] data_IP_ID,
    ip_cfg_regbank_if.slave     bus,
    output logic                start_o,
    input  logic                ip_done_i,
    output logic                irq_o
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP,
        RELEASE
    } state_t;

    state_t state, state_nx;

    logic                wr_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [SIZE_REG-1:0] wdata_q;
    logic [SIZE_REG-1:0] rdata_q;
    logic                err_q;

    logic                irq_en;
    logic                busy;
    logic                done;
    logic [SIZE_REG-1:0] scratch;
    logic [CNT_W-1:0]    cnt;

    logic                acc;
    logic                wr_en;
    logic [SIZE_REG-1:0] rd_mux;
    logic                err_mux;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.req_i) state_nx = ACCESS;
            ACCESS:  state_nx = RESP;
            RESP:    state_nx = RELEASE;
            RELEASE: if (!bus.req_i) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Request fields are frozen at acceptance so later bus changes are inert
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (state == IDLE && bus.req_i) begin
            wr_q    <= bus.wr_i;
            addr_q  <= bus.addr_i;
            wdata_q <= bus.wdata_i;
        end
    end

    assign acc   = (state == ACCESS);
    assign wr_en = acc & wr_q;

    always_comb begin
        rd_mux  = '0;
        err_mux = 1'b0;
        case (addr_q)
            ADDR_W'(0): begin
                rd_mux  = data_IP_ID;
                err_mux = wr_q;
            end
            ADDR_W'(1): rd_mux = SIZE_REG'({irq_en, 1'b0});
            ADDR_W'(2): rd_mux = SIZE_REG'({done, busy});
            ADDR_W'(3): rd_mux = scratch;
            ADDR_W'(4): rd_mux = SIZE_REG'(cnt);
            default:    err_mux = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (acc) begin
            rdata_q <= wr_q ? '0 : rd_mux;
            err_q   <= err_mux;
        end
    end

    assign bus.ack_o   = (state == RESP);
    assign bus.rdata_o = bus.ack_o ? rdata_q : '0;
    assign bus.err_o   = bus.ack_o & err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_en  <= 1'b0;
            scratch <= '0;
            start_o <= 1'b0;
        end else begin
            start_o <= wr_en && addr_q == ADDR_W'(1) && wdata_q[0];
            if (wr_en && addr_q == ADDR_W'(1)) irq_en <= wdata_q[1];
            if (wr_en && addr_q == ADDR_W'(3)) scratch <= wdata_q;
        end
    end

    // Priorities: start beats done for busy, done-set beats W1C,
    // counter clear beats increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
            cnt  <= '0;
            irq_o <= 1'b0;
        end else begin
            if (start_o)        busy <= 1'b1;
            else if (ip_done_i) busy <= 1'b0;
            if (ip_done_i)
                done <= 1'b1;
            else if (wr_en && addr_q == ADDR_W'(2) && wdata_q[1])
                done <= 1'b0;
            if (wr_en && addr_q == ADDR_W'(4)) cnt <= '0;
            else if (ip_done_i)                cnt <= cnt + 1'b1;
            irq_o <= irq_en & done;
        end
    end

endmodule

// File: tb/tb_ip_cfg_regbank.sv
// Directed bench for ip_cfg_regbank: handshake timing, register map,
// start/done/irq interplay, counter wrap and reset mid-access.
module tb_ip_cfg_regbank;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] data_IP_ID = 32'h0000_1000;
    logic        start_o;
    logic        ip_done_i = 1'b0;
    logic        irq_o;

    int tests = 0;
    int fails = 0;
    int start_cnt = 0;

    logic [31:0] rd;
    logic        er;
    int          n;

    ip_cfg_regbank_if #(.SIZE_REG(32), .ADDR_W(3)) bus ();

    ip_cfg_regbank #(.SIZE_REG(32), .ADDR_W(3), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_IP_ID (data_IP_ID),
        .bus        (bus),
        .start_o    (start_o),
        .ip_done_i  (ip_done_i),
        .irq_o      (irq_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (start_o) start_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic acc(input logic w, input logic [2:0] a,
                       input logic [31:0] d, input bit pd,
                       output logic [31:0] r, output logic e);
        @(negedge clk);
        bus.req_i   = 1'b1;
        bus.wr_i    = w;
        bus.addr_i  = a;
        bus.wdata_i = d;
        @(posedge clk); #1;
        bus.wr_i    = ~w;
        bus.addr_i  = ~a;
        bus.wdata_i = ~d;
        if (pd) ip_done_i = 1'b1;
        chk("ack_lat1", 32'(bus.ack_o), 32'd0);
        @(posedge clk); #1;
        ip_done_i = 1'b0;
        chk("ack_lat2", 32'(bus.ack_o), 32'd1);
        r = bus.rdata_o;
        e = bus.err_o;
        @(negedge clk);
        bus.req_i = 1'b0;
        @(posedge clk); #1;
        chk("ack_1cyc", 32'(bus.ack_o), 32'd0);
        chk("rdata_idle", bus.rdata_o, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        bus.req_i   = 1'b0;
        bus.wr_i    = 1'b0;
        bus.addr_i  = '0;
        bus.wdata_i = '0;
        #1;
        chk("rst_ack", 32'(bus.ack_o), 32'd0);
        chk("rst_rdata", bus.rdata_o, 32'd0);
        chk("rst_err", 32'(bus.err_o), 32'd0);
        chk("rst_start", 32'(start_o), 32'd0);
        chk("rst_irq", 32'(irq_o), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        acc(1'b0, 3'd0, 32'h0, 1'b0, rd, er);
        chk("id_rd", rd, 32'h0000_1000);
        chk("id_rd_err", 32'(er), 32'd0);

        acc(1'b1, 3'd3, 32'hA5A5_5A5A, 1'b0, rd, er);
        chk("scr_wr_err", 32'(er), 32'd0);
        acc(1'b0, 3'd3, 32'h0, 1'b0, rd, er);
        chk("scr_rd", rd, 32'hA5A5_5A5A);
        acc(1'b1, 3'd0, 32'hFFFF_FFFF, 1'b0, rd, er);
        chk("id_wr_err", 32'(er), 32'd1);
        acc(1'b0, 3'd0, 32'h0, 1'b0, rd, er);
        chk("id_rd2", rd, 32'h0000_1000);
        chk("id_rd2_err", 32'(er), 32'd0);
        acc(1'b0, 3'd6, 32'h0, 1'b0, rd, er);
        chk("a6_rd", rd, 32'h0);
        chk("a6_err", 32'(er), 32'd1);

        acc(1'b1, 3'd1, 32'h3, 1'b0, rd, er);
        chk("start_pulses", 32'(start_cnt), 32'd1);
        chk("start_low", 32'(start_o), 32'd0);
        acc(1'b0, 3'd1, 32'h0, 1'b0, rd, er);
        chk("ctrl_rd", rd, 32'h2);
        acc(1'b0, 3'd2, 32'h0, 1'b0, rd, er);
        chk("stat_busy", rd, 32'h1);
        chk("irq_pre", 32'(irq_o), 32'd0);

        @(negedge clk) ip_done_i = 1'b1;
        @(posedge clk); #1;
        ip_done_i = 1'b0;
        chk("irq_lag", 32'(irq_o), 32'd0);
        @(posedge clk); #1;
        chk("irq_set", 32'(irq_o), 32'd1);
        acc(1'b0, 3'd2, 32'h0, 1'b0, rd, er);
        chk("stat_done", rd, 32'h2);
        acc(1'b1, 3'd2, 32'h2, 1'b0, rd, er);
        chk("irq_clr", 32'(irq_o), 32'd0);
        acc(1'b0, 3'd2, 32'h0, 1'b0, rd, er);
        chk("stat_clr", rd, 32'h0);

        @(negedge clk);
        bus.req_i  = 1'b1;
        bus.wr_i   = 1'b0;
        bus.addr_i = 3'd3;
        n = 0;
        repeat (6) begin
            @(posedge clk); #1;
            n += int'(bus.ack_o);
        end
        chk("hold_one_ack", 32'(n), 32'd1);
        @(negedge clk) bus.req_i = 1'b0;
        @(negedge clk) bus.req_i = 1'b1;
        n = 0;
        repeat (4) begin
            @(posedge clk); #1;
            n += int'(bus.ack_o);
        end
        chk("reassert_ack", 32'(n), 32'd1);
        @(negedge clk) bus.req_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        acc(1'b1, 3'd4, 32'h0, 1'b0, rd, er);
        @(negedge clk) ip_done_i = 1'b1;
        repeat (65537) @(posedge clk);
        @(negedge clk) ip_done_i = 1'b0;
        acc(1'b0, 3'd4, 32'h0, 1'b0, rd, er);
        chk("cnt_wrap", rd, 32'h1);
        acc(1'b1, 3'd4, 32'h0, 1'b1, rd, er);
        acc(1'b0, 3'd4, 32'h0, 1'b0, rd, er);
        chk("cnt_clr_wins", rd, 32'h0);
        acc(1'b1, 3'd2, 32'h2, 1'b1, rd, er);
        acc(1'b0, 3'd2, 32'h0, 1'b0, rd, er);
        chk("done_set_wins", rd, 32'h2);
        chk("irq_still", 32'(irq_o), 32'd1);

        @(negedge clk);
        bus.req_i   = 1'b1;
        bus.wr_i    = 1'b1;
        bus.addr_i  = 3'd3;
        bus.wdata_i = 32'h0000_1234;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_ack", 32'(bus.ack_o), 32'd0);
        chk("mid_rst_start", 32'(start_o), 32'd0);
        chk("mid_rst_irq", 32'(irq_o), 32'd0);
        chk("mid_rst_rdata", bus.rdata_o, 32'd0);
        bus.req_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        acc(1'b0, 3'd3, 32'h0, 1'b0, rd, er);
        chk("scr_after_rst", rd, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
